// File: rtl/ct_ifu_rst_inv_seq.sv
// ct_ifu_rst_inv_seq: reset-time icache invalidation sequencer feeding the IFU vector FSM
// Ports:
//   vec_sm_clk / cpurst_b       gated vector-SM clock, async active-low reset
//   ifu_cp0_rst_inv_req         one-cycle start pulse from the vector FSM
//   icache_inv_gnt              arbiter grant; the write at the current index lands on a granted edge
//   rst_inv_icache_req/index/way_mask  invalidate write request toward the array arbiter
//   cp0_ifu_rst_inv_done        level done flag releasing the vector FSM from RESET
//   rst_inv_busy                walk in progress (fetch blocked)
//   rst_inv_debug_st            one-hot {DONE, INV, IDLE}
module ct_ifu_rst_inv_seq #(
  parameter int INDEX_WIDTH = 8,
  parameter int WAY_NUM     = 2
) (
  input  logic                   vec_sm_clk,
  input  logic                   cpurst_b,
  input  logic                   ifu_cp0_rst_inv_req,
  input  logic                   icache_inv_gnt,
  output logic                   rst_inv_icache_req,
  output logic [INDEX_WIDTH-1:0] rst_inv_icache_index,
  output logic [WAY_NUM-1:0]     rst_inv_icache_way_mask,
  output logic                   cp0_ifu_rst_inv_done,
  output logic                   rst_inv_busy,
  output logic [2:0]             rst_inv_debug_st
);
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    INV  = 3'b010,
    DONE = 3'b100
  } state_e;
  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end
  // The counter wraps to zero naturally on the final granted write, so DONE reads index 0.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = ifu_cp0_rst_inv_req ? INV : state_q;
        index_d = ifu_cp0_rst_inv_req ? '0 : index_q;
      end
      INV: begin
        index_d = icache_inv_gnt ? index_q + INDEX_WIDTH'(1) : index_q;
        state_d = (icache_inv_gnt && &index_q) ? DONE : INV;
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end
  assign rst_inv_icache_req      = state_q == INV;
  assign rst_inv_busy            = state_q == INV;
  assign rst_inv_icache_index    = index_q;
  assign rst_inv_icache_way_mask = {WAY_NUM{state_q == INV}};
  assign cp0_ifu_rst_inv_done    = state_q == DONE;
  assign rst_inv_debug_st        = state_q;
endmodule

// File: tb/tb_ct_ifu_rst_inv_seq.sv
// tb_ct_ifu_rst_inv_seq: directed self-checking bench for the reset invalidation sequencer
module tb_ct_ifu_rst_inv_seq;
  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       req = 1'b0, gnt = 1'b1;
  logic       req2 = 1'b0, gnt2 = 1'b1;
  logic       o_req, o_done, o_busy, o2_req, o2_done, o2_busy;
  logic [7:0] o_idx;
  logic [1:0] o_mask, o2_idx, o2_mask;
  logic [2:0] o_dbg, o2_dbg;
  int         vecs = 0, miss = 0;
  always #5 clk = ~clk;
  ct_ifu_rst_inv_seq #(.INDEX_WIDTH(8), .WAY_NUM(2)) dut (
    .vec_sm_clk(clk), .cpurst_b(rst_b), .ifu_cp0_rst_inv_req(req), .icache_inv_gnt(gnt),
    .rst_inv_icache_req(o_req), .rst_inv_icache_index(o_idx), .rst_inv_icache_way_mask(o_mask),
    .cp0_ifu_rst_inv_done(o_done), .rst_inv_busy(o_busy), .rst_inv_debug_st(o_dbg));
  ct_ifu_rst_inv_seq #(.INDEX_WIDTH(2), .WAY_NUM(2)) dut2 (
    .vec_sm_clk(clk), .cpurst_b(rst_b), .ifu_cp0_rst_inv_req(req2), .icache_inv_gnt(gnt2),
    .rst_inv_icache_req(o2_req), .rst_inv_icache_index(o2_idx), .rst_inv_icache_way_mask(o2_mask),
    .cp0_ifu_rst_inv_done(o2_done), .rst_inv_busy(o2_busy), .rst_inv_debug_st(o2_dbg));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_inv(input string tag, input int idx);
    chk({tag, " req"}, {31'd0, o_req}, 32'd1);
    chk({tag, " idx"}, {24'd0, o_idx}, idx);
    chk({tag, " mask"}, {30'd0, o_mask}, 32'd3);
    chk({tag, " busy"}, {31'd0, o_busy}, 32'd1);
    chk({tag, " done"}, {31'd0, o_done}, 32'd0);
    chk({tag, " dbg"}, {29'd0, o_dbg}, 32'b010);
  endtask
  task automatic chk_done(input string tag);
    chk({tag, " done"}, {31'd0, o_done}, 32'd1);
    chk({tag, " busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, " req"}, {31'd0, o_req}, 32'd0);
    chk({tag, " mask"}, {30'd0, o_mask}, 32'd0);
    chk({tag, " idx"}, {24'd0, o_idx}, 32'd0);
    chk({tag, " dbg"}, {29'd0, o_dbg}, 32'b100);
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, " req"}, {31'd0, o_req}, 32'd0);
    chk({tag, " done"}, {31'd0, o_done}, 32'd0);
    chk({tag, " busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, " idx"}, {24'd0, o_idx}, 32'd0);
    chk({tag, " mask"}, {30'd0, o_mask}, 32'd0);
    chk({tag, " dbg"}, {29'd0, o_dbg}, 32'b001);
    chk({tag, " dbg2"}, {29'd0, o2_dbg}, 32'b001);
    chk({tag, " req2"}, {31'd0, o2_req}, 32'd0);
  endtask
  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask
  initial begin
    #2 rst_b = 1'b0;
    #1 chk_rst("reset");
    tick();
    chk_rst("reset_held");
    #1 rst_b = 1'b1;
    tick();
    tick();
    chk_rst("idle");
    // nominal walk with a duplicate request injected at index 0x80
    pulse_req();
    for (int i = 0; i < 256; i++) begin
      chk_inv("walk", i);
      req = (i == 8'h80);
      tick();
      req = 1'b0;
    end
    chk_done("walk_end");
    tick();
    tick();
    chk_done("done_hold");
    // restart from DONE: nominal second walk
    pulse_req();
    chk_inv("restart_first", 0);
    for (int i = 0; i < 256; i++) begin
      chk_inv("restart", i);
      tick();
    end
    chk_done("restart_end");
    // restart again, with grant dropped for 5 cycles at index 0x40
    pulse_req();
    for (int i = 0; i < 256; i++) begin
      if (i == 8'h40) begin
        gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk_inv("stall", 8'h40);
          tick();
        end
        gnt = 1'b1;
      end
      chk_inv("bp", i);
      tick();
    end
    chk_done("bp_end");
    // reset mid-walk at index 0x33
    pulse_req();
    for (int i = 0; i < 8'h33; i++) tick();
    chk_inv("pre_abort", 8'h33);
    #2 rst_b = 1'b0;
    #1 chk_rst("abort");
    #1 rst_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_done !== 1'b0 || o_req !== 1'b0) chk("no_done_after_abort", {30'd0, o_done, o_req}, 32'd0);
    end
    chk_rst("post_abort_idle");
    pulse_req();
    for (int i = 0; i < 256; i++) begin
      chk_inv("rewalk", i);
      tick();
    end
    chk_done("rewalk_end");
    // minimum-size instance: INDEX_WIDTH=2
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("small req", {31'd0, o2_req}, 32'd1);
      chk("small idx", {30'd0, o2_idx}, i);
      chk("small mask", {30'd0, o2_mask}, 32'd3);
      chk("small done", {31'd0, o2_done}, 32'd0);
      tick();
    end
    chk("small done_end", {31'd0, o2_done}, 32'd1);
    chk("small idx_end", {30'd0, o2_idx}, 32'd0);
    chk("small busy_end", {31'd0, o2_busy}, 32'd0);
    chk("small dbg_end", {29'd0, o2_dbg}, 32'b100);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
